// File: rtl/text_console_ctrl.sv
// Text console engine: accepts character codes, tracks the cursor, writes the character RAM and scrolls via a row offset.
// Optional build macro TEXT_CONSOLE_TAB_EN adds horizontal-tab (0x09) handling.
module text_console_ctrl #(
  parameter int                COLS      = 80,
  parameter int                ROWS      = 30,
  parameter int                CHAR_W    = 7,
  parameter logic [CHAR_W-1:0] FILL_CHAR = '0,
  localparam int               AW        = $clog2(COLS*ROWS),
  localparam int               XW        = $clog2(COLS),
  localparam int               YW        = $clog2(ROWS)
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [CHAR_W-1:0] DIN,
  input  logic              DIN_VALID,
  output logic              DIN_READY,
  output logic              FB_WE,
  output logic [AW-1:0]     FB_ADDR,
  output logic [CHAR_W-1:0] FB_DATA,
  output logic [YW-1:0]     SCROLL_ROW,
  output logic [XW-1:0]     CURSOR_X,
  output logic [YW-1:0]     CURSOR_Y,
  output logic              BUSY
);

  typedef enum logic [1:0] {IDLE, EXEC, CLEAR, CLRLINE} state_t;

  localparam logic [CHAR_W-1:0] C_BS  = CHAR_W'('h08);
  localparam logic [CHAR_W-1:0] C_LF  = CHAR_W'('h0A);
  localparam logic [CHAR_W-1:0] C_CR  = CHAR_W'('h0D);
  localparam logic [CHAR_W-1:0] C_SP  = CHAR_W'('h20);
  localparam logic [CHAR_W-1:0] C_DEL = CHAR_W'('h7F);

  state_t            state, state_nx;
  logic [CHAR_W-1:0] code_q;
  logic [AW-1:0]     cnt, cnt_nx, line_base, line_base_nx, fb_addr_nx;
  logic [XW-1:0]     cx_nx;
  logic [YW-1:0]     cy_nx, scr_nx;
  logic              fb_we_nx;
  logic [CHAR_W-1:0] fb_data_nx;
  logic              xfer, is_print, at_last_col, at_bottom, do_lf, need_scroll;

  // Logical row -> physical row by compare-and-subtract, then row*COLS+col.
  function automatic logic [AW-1:0] cell_addr(input logic [YW-1:0] y,
                                              input logic [YW-1:0] s,
                                              input logic [XW-1:0] x);
    logic [YW:0] prow;
    prow = {1'b0, y} + {1'b0, s};
    if (prow >= (YW+1)'(ROWS)) prow = prow - (YW+1)'(ROWS);
    return AW'(int'(prow) * COLS + int'(x));
  endfunction

  assign xfer        = DIN_VALID && DIN_READY;
  assign is_print    = (code_q >= C_SP) && (code_q != C_DEL);
  assign at_last_col = (CURSOR_X == XW'(COLS-1));
  assign at_bottom   = (CURSOR_Y == YW'(ROWS-1));

`ifdef TEXT_CONSOLE_TAB_EN
  localparam logic [CHAR_W-1:0] C_HT = CHAR_W'('h09);
  logic          is_tab, tab_ovf;
  logic [XW:0]   tab_pos;
  assign is_tab  = (code_q == C_HT);
  assign tab_pos = ({1'b0, CURSOR_X} | (XW+1)'(7)) + (XW+1)'(1);
  assign tab_ovf = (tab_pos >= (XW+1)'(COLS));
  assign do_lf   = (code_q == C_LF) || (is_print && at_last_col) || (is_tab && tab_ovf);
`else
  assign do_lf   = (code_q == C_LF) || (is_print && at_last_col);
`endif
  assign need_scroll = do_lf && at_bottom;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= CLEAR;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (xfer) state_nx = EXEC;
      EXEC:    if (code_q == C_DEL)  state_nx = CLEAR;
               else if (need_scroll) state_nx = CLRLINE;
               else                  state_nx = IDLE;
      CLEAR:   if (cnt == AW'(COLS*ROWS-1)) state_nx = IDLE;
      CLRLINE: if (cnt == AW'(COLS-1))      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cx_nx        = CURSOR_X;
    cy_nx        = CURSOR_Y;
    scr_nx       = SCROLL_ROW;
    fb_we_nx     = 1'b0;
    fb_addr_nx   = FB_ADDR;
    fb_data_nx   = FB_DATA;
    cnt_nx       = cnt;
    line_base_nx = line_base;
    case (state)
      EXEC: begin
        if (code_q == C_CR) begin
          cx_nx = '0;
        end else if (code_q == C_BS) begin
          if (CURSOR_X != '0) begin
            cx_nx      = CURSOR_X - XW'(1);
            fb_we_nx   = 1'b1;
            fb_addr_nx = cell_addr(CURSOR_Y, SCROLL_ROW, CURSOR_X - XW'(1));
            fb_data_nx = FILL_CHAR;
          end
`ifdef TEXT_CONSOLE_TAB_EN
        end else if (is_tab) begin
          cx_nx = tab_ovf ? '0 : tab_pos[XW-1:0];
`endif
        end else if (is_print) begin
          fb_we_nx   = 1'b1;
          fb_addr_nx = cell_addr(CURSOR_Y, SCROLL_ROW, CURSOR_X);
          fb_data_nx = code_q;
          cx_nx      = at_last_col ? '0 : CURSOR_X + XW'(1);
        end
        // The old top physical row becomes the new bottom row after a scroll.
        if (do_lf) begin
          if (!at_bottom) begin
            cy_nx = CURSOR_Y + YW'(1);
          end else begin
            scr_nx       = (SCROLL_ROW == YW'(ROWS-1)) ? '0 : SCROLL_ROW + YW'(1);
            line_base_nx = AW'(int'(SCROLL_ROW) * COLS);
            cnt_nx       = '0;
          end
        end
        if (code_q == C_DEL) cnt_nx = '0;
      end
      CLEAR: begin
        fb_we_nx   = 1'b1;
        fb_addr_nx = cnt;
        fb_data_nx = FILL_CHAR;
        cnt_nx     = cnt + AW'(1);
        if (cnt == AW'(COLS*ROWS-1)) begin
          cx_nx  = '0;
          cy_nx  = '0;
          scr_nx = '0;
        end
      end
      CLRLINE: begin
        fb_we_nx   = 1'b1;
        fb_addr_nx = line_base + cnt;
        fb_data_nx = FILL_CHAR;
        cnt_nx     = cnt + AW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      CURSOR_X   <= '0;
      CURSOR_Y   <= '0;
      SCROLL_ROW <= '0;
      FB_WE      <= 1'b0;
      FB_ADDR    <= '0;
      FB_DATA    <= FILL_CHAR;
      cnt        <= '0;
      line_base  <= '0;
      DIN_READY  <= 1'b0;
      BUSY       <= 1'b1;
    end else begin
      CURSOR_X   <= cx_nx;
      CURSOR_Y   <= cy_nx;
      SCROLL_ROW <= scr_nx;
      FB_WE      <= fb_we_nx;
      FB_ADDR    <= fb_addr_nx;
      FB_DATA    <= fb_data_nx;
      cnt        <= cnt_nx;
      line_base  <= line_base_nx;
      DIN_READY  <= (state_nx == IDLE);
      BUSY       <= (state_nx == CLEAR) || (state_nx == CLRLINE);
    end
  end

  always_ff @(posedge CLK) begin
    if (xfer) code_q <= DIN;
  end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Scoreboard bench for text_console_ctrl: a cursor/scroll model queues expected RAM writes, sampled on the falling edge.
module tb_text_console_ctrl;
  localparam int COLS = 80, ROWS = 30, CHAR_W = 7, AW = 12, XW = 7, YW = 5, N = COLS*ROWS;

  logic              CLK = 1'b0;
  logic              RESET_N = 1'b1;
  logic [CHAR_W-1:0] DIN = '0;
  logic              DIN_VALID = 1'b0;
  logic              DIN_READY, FB_WE, BUSY;
  logic [AW-1:0]     FB_ADDR;
  logic [CHAR_W-1:0] FB_DATA;
  logic [YW-1:0]     SCROLL_ROW, CURSOR_Y;
  logic [XW-1:0]     CURSOR_X;

  text_console_ctrl #(.COLS(COLS), .ROWS(ROWS), .CHAR_W(CHAR_W), .FILL_CHAR('0)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY),
    .FB_WE(FB_WE), .FB_ADDR(FB_ADDR), .FB_DATA(FB_DATA), .SCROLL_ROW(SCROLL_ROW),
    .CURSOR_X(CURSOR_X), .CURSOR_Y(CURSOR_Y), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int checks = 0, failures = 0, cyc = 0;
  int qa[$], qd[$];
  int mx = 0, my = 0, ms = 0;

  // One clock; any write seen on the falling edge is matched against the queue.
  task automatic step();
    int ea, ed;
    @(negedge CLK);
    cyc++;
    if (RESET_N && FB_WE) begin
      checks++;
      if (qa.size() == 0) begin
        failures++;
        $display("FAIL fb_write unexpected addr=%0d data=0x%0h", FB_ADDR, FB_DATA);
      end else begin
        ea = qa.pop_front();
        ed = qd.pop_front();
        if (FB_ADDR !== AW'(ea) || FB_DATA !== CHAR_W'(ed)) begin
          failures++;
          $display("FAIL fb_write got addr=%0d data=0x%0h want addr=%0d data=0x%0h",
                   FB_ADDR, FB_DATA, ea, ed);
        end
      end
    end
  endtask

  task automatic push(int a, int d);
    qa.push_back(a);
    qd.push_back(d);
  endtask

  function automatic int maddr(int x);
    return ((my + ms) % ROWS) * COLS + x;
  endfunction

  task automatic model_lf();
    if (my < ROWS-1) my++;
    else begin
      for (int i = 0; i < COLS; i++) push(ms*COLS + i, 0);
      ms = (ms + 1) % ROWS;
    end
  endtask

  task automatic model(int c);
    if (c == 'h0A) model_lf();
    else if (c == 'h0D) mx = 0;
    else if (c == 'h08) begin
      if (mx > 0) begin mx--; push(maddr(mx), 0); end
    end else if (c == 'h7F) begin
      for (int i = 0; i < N; i++) push(i, 0);
      mx = 0; my = 0; ms = 0;
`ifdef TEXT_CONSOLE_TAB_EN
    end else if (c == 'h09) begin
      int t;
      t = (mx/8 + 1) * 8;
      if (t >= COLS) begin mx = 0; model_lf(); end
      else mx = t;
`endif
    end else if (c >= 'h20) begin
      push(maddr(mx), c);
      if (mx == COLS-1) begin mx = 0; model_lf(); end
      else mx++;
    end
  endtask

  // Returns at the falling edge right after the accepting clock edge.
  task automatic send(int c);
    bit ok;
    ok = 1'b0;
    model(c);
    DIN = CHAR_W'(c);
    DIN_VALID = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      if (DIN_READY === 1'b1) begin ok = 1'b1; step(); break; end
      step();
    end
    DIN_VALID = 1'b0;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL send_timeout code=0x%0h", c);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (DIN_READY !== 1'b1 && n < 5000) begin step(); n++; end
    checks++;
    if (n >= 5000) begin failures++; $display("FAIL idle_timeout waited=%0d limit=5000", n); end
  endtask

  task automatic test_reset();
    int n;
    RESET_N = 1'b0;
    qa.delete(); qd.delete();
    mx = 0; my = 0; ms = 0;
    #1;
    checks++;
    if ({BUSY, DIN_READY, FB_WE, FB_ADDR, FB_DATA, CURSOR_X, CURSOR_Y, SCROLL_ROW} !==
        {1'b1, 1'b0, 1'b0, 12'd0, 7'd0, 7'd0, 5'd0, 5'd0}) begin
      failures++;
      $display("FAIL reset_state busy=%b rdy=%b we=%b addr=%0d data=%0h x=%0d y=%0d s=%0d want busy=1 rdy=0 rest 0",
               BUSY, DIN_READY, FB_WE, FB_ADDR, FB_DATA, CURSOR_X, CURSOR_Y, SCROLL_ROW);
    end
    step(); step();
    RESET_N = 1'b1;
    for (int i = 0; i < N; i++) push(i, 0);
    n = 0;
    while (BUSY === 1'b1 && n < 3000) begin n++; step(); end
    checks++;
    if (n != N) begin failures++; $display("FAIL reset_busy_cycles got=%0d want=%0d", n, N); end
    checks++;
    if ({DIN_READY, CURSOR_X, CURSOR_Y, SCROLL_ROW} !== {1'b1, 7'd0, 5'd0, 5'd0}) begin
      failures++;
      $display("FAIL post_clear_state rdy=%b x=%0d y=%0d s=%0d want 1 0 0 0", DIN_READY, CURSOR_X, CURSOR_Y, SCROLL_ROW);
    end
    step();
    checks++;
    if (qa.size() != 0) begin failures++; $display("FAIL clear_writes missing=%0d want 0", qa.size()); end
  endtask

  task automatic test_basic();
    send('h41); step();
    checks++;
    if (FB_WE !== 1'b1) begin failures++; $display("FAIL write_latency_a we=%b want 1", FB_WE); end
    send('h42); step();
    checks++;
    if (FB_WE !== 1'b1) begin failures++; $display("FAIL write_latency_b we=%b want 1", FB_WE); end
    wait_idle();
    checks++;
    if ({CURSOR_X, CURSOR_Y, SCROLL_ROW} !== {7'd2, 5'd0, 5'd0}) begin
      failures++; $display("FAIL basic_cursor x=%0d y=%0d s=%0d want 2 0 0", CURSOR_X, CURSOR_Y, SCROLL_ROW);
    end
  endtask

  task automatic test_row_wrap();
    send('h0D);
    for (int i = 0; i < COLS; i++) send('h30 + (i % 64));
    wait_idle();
    checks++;
    if ({CURSOR_X, CURSOR_Y, SCROLL_ROW, 7'(qa.size())} !== {7'd0, 5'd1, 5'd0, 7'd0}) begin
      failures++;
      $display("FAIL row_wrap x=%0d y=%0d s=%0d pending=%0d want 0 1 0 0", CURSOR_X, CURSOR_Y, SCROLL_ROW, qa.size());
    end
  endtask

  task automatic test_scroll();
    int n, k;
    while (my < ROWS-1) send('h0A);
    wait_idle();
    send('h0A);
    n = 0; k = 0;
    do begin step(); if (FB_WE === 1'b1) n++; k++; end while (DIN_READY !== 1'b1 && k < 200);
    checks++;
    if (n != COLS || SCROLL_ROW !== 5'd1 || CURSOR_Y !== 5'd29) begin
      failures++;
      $display("FAIL scroll_clrline writes=%0d s=%0d y=%0d want 80 1 29", n, SCROLL_ROW, CURSOR_Y);
    end
    send('h43);
    wait_idle();
    checks++;
    if ({CURSOR_X, CURSOR_Y, SCROLL_ROW} !== {7'(mx), 5'(my), 5'(ms)} || qa.size() != 0) begin
      failures++;
      $display("FAIL scroll_write x=%0d y=%0d s=%0d pending=%0d want %0d %0d %0d 0",
               CURSOR_X, CURSOR_Y, SCROLL_ROW, qa.size(), mx, my, ms);
    end
  endtask

  task automatic test_scroll_wrap();
    int n;
    for (int i = 0; i < 28; i++) send('h0A);
    wait_idle();
    checks++;
    if (SCROLL_ROW !== 5'd29) begin failures++; $display("FAIL scroll_29 s=%0d want 29", SCROLL_ROW); end
    send('h0A);
    wait_idle();
    checks++;
    if ({CURSOR_Y, SCROLL_ROW} !== {5'd29, 5'd0}) begin
      failures++; $display("FAIL scroll_wrap y=%0d s=%0d want 29 0", CURSOR_Y, SCROLL_ROW);
    end
    send('h0D);
    for (int i = 0; i < COLS; i++) send('h21 + (i % 90));
    wait_idle();
    checks++;
    if ({CURSOR_X, CURSOR_Y, SCROLL_ROW, 7'(qa.size())} !== {7'd0, 5'd29, 5'd1, 7'd0}) begin
      failures++;
      $display("FAIL bottom_line_wrap x=%0d y=%0d s=%0d pending=%0d want 0 29 1 0", CURSOR_X, CURSOR_Y, SCROLL_ROW, qa.size());
    end
    send('h7F);
    step();
    n = 0;
    while (BUSY === 1'b1 && n < 3000) begin n++; step(); end
    checks++;
    if (n != N) begin failures++; $display("FAIL clear_busy_cycles got=%0d want=%0d", n, N); end
    wait_idle();
    checks++;
    if ({CURSOR_X, CURSOR_Y, SCROLL_ROW, 12'(qa.size())} !== {7'd0, 5'd0, 5'd0, 12'd0}) begin
      failures++;
      $display("FAIL clear_state x=%0d y=%0d s=%0d pending=%0d want 0 0 0 0", CURSOR_X, CURSOR_Y, SCROLL_ROW, qa.size());
    end
  endtask

  task automatic test_bs_ctrl();
    send('h08); step();
    checks++;
    if (FB_WE !== 1'b0) begin failures++; $display("FAIL bs_col0_write we=%b want 0", FB_WE); end
    send('h01);
    wait_idle();
    checks++;
    if ({CURSOR_X, CURSOR_Y} !== {7'd0, 5'd0}) begin
      failures++; $display("FAIL bs_col0_cursor x=%0d y=%0d want 0 0", CURSOR_X, CURSOR_Y);
    end
`ifdef TEXT_CONSOLE_TAB_EN
    for (int i = 0; i < 75; i++) send('h61 + (i % 26));
    send('h09);
    wait_idle();
    checks++;
    if ({CURSOR_X, CURSOR_Y} !== {7'd0, 5'd1}) begin
      failures++; $display("FAIL tab_overflow x=%0d y=%0d want 0 1", CURSOR_X, CURSOR_Y);
    end
    for (int i = 0; i < 3; i++) send('h31 + i);
    send('h09);
    wait_idle();
    checks++;
    if (CURSOR_X !== 7'd8) begin failures++; $display("FAIL tab_x3 x=%0d want 8", CURSOR_X); end
`else
    for (int i = 0; i < 3; i++) send('h31 + i);
    send('h09); step();
    checks++;
    if (FB_WE !== 1'b0) begin failures++; $display("FAIL ht_ignored_write we=%b want 0", FB_WE); end
    wait_idle();
    checks++;
    if (CURSOR_X !== 7'd3) begin failures++; $display("FAIL ht_ignored_x x=%0d want 3", CURSOR_X); end
`endif
    send('h08);
    wait_idle();
    checks++;
    if ({CURSOR_X, CURSOR_Y, SCROLL_ROW, 7'(qa.size())} !== {7'(mx), 5'(my), 5'(ms), 7'd0}) begin
      failures++;
      $display("FAIL bs_erase x=%0d y=%0d s=%0d pending=%0d want %0d %0d %0d 0",
               CURSOR_X, CURSOR_Y, SCROLL_ROW, qa.size(), mx, my, ms);
    end
  endtask

  task automatic test_back_to_back();
    int c0, c1;
    send('h50);
    c0 = cyc;
    for (int i = 1; i < 5; i++) begin
      send('h50 + i);
      c1 = cyc;
      checks++;
      if (c1 - c0 != 2) begin failures++; $display("FAIL b2b_spacing idx=%0d got=%0d want=2", i, c1 - c0); end
      c0 = c1;
    end
    while (my < ROWS-1) send('h0A);
    send('h0A);
    c0 = cyc;
    send('h44);
    c1 = cyc;
    checks++;
    if (c1 - c0 != 2 + COLS) begin failures++; $display("FAIL held_during_sweep got=%0d want=%0d", c1 - c0, 2 + COLS); end
    wait_idle();
    checks++;
    if ({CURSOR_X, CURSOR_Y, SCROLL_ROW, 7'(qa.size())} !== {7'(mx), 5'(my), 5'(ms), 7'd0}) begin
      failures++;
      $display("FAIL b2b_state x=%0d y=%0d s=%0d pending=%0d want %0d %0d %0d 0",
               CURSOR_X, CURSOR_Y, SCROLL_ROW, qa.size(), mx, my, ms);
    end
  endtask

  task automatic test_reset_mid();
    send('h7F);
    for (int i = 0; i < 100; i++) step();
    test_reset();
    send('h41);
    test_reset();
    send('h45);
    wait_idle();
    checks++;
    if ({CURSOR_X, CURSOR_Y, SCROLL_ROW, 7'(qa.size())} !== {7'd1, 5'd0, 5'd0, 7'd0}) begin
      failures++;
      $display("FAIL after_mid_reset x=%0d y=%0d s=%0d pending=%0d want 1 0 0 0", CURSOR_X, CURSOR_Y, SCROLL_ROW, qa.size());
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    test_row_wrap();
    test_scroll();
    test_scroll_wrap();
    test_bs_ctrl();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/text_console_ctrl.md
Name: text_console_ctrl

Overview:
- CPU-facing terminal engine for the text-mode VGA GPU.
- Accepts one character code at a time over a valid/ready handshake and tracks the cursor.
- Writes glyph codes into the character-buffer RAM through a single write port.
- Scrolls in hardware with a row-offset register, so the display side never sees a data copy; it reads the same RAM using SCROLL_ROW.

Parameters:
COLS, 80, characters per row
ROWS, 30, visible character rows
CHAR_W, 7, bits per character code
FILL_CHAR, 0, code written by clear and scroll operations
AW, $clog2(COLS*ROWS), framebuffer address width (derived, not overridden)

Ports:
CLK  in  1  system/CPU-domain clock; all logic on rising edge
RESET_N  in  1  asynchronous, active-low reset
DIN  in  CHAR_W  incoming character/control code
DIN_VALID  in  1  DIN holds a code
DIN_READY  out  1  block can accept a code this cycle
FB_WE  out  1  framebuffer write strobe, one cycle per cell
FB_ADDR  out  AW  physical address, row*COLS+col
FB_DATA  out  CHAR_W  code to write
SCROLL_ROW  out  $clog2(ROWS)  physical RAM row shown at screen top
CURSOR_X  out  $clog2(COLS)  logical cursor column
CURSOR_Y  out  $clog2(ROWS)  logical cursor row (0 = top of screen)
BUSY  out  1  clear or scroll sweep in progress

Behaviour:
- All outputs are registered.
- Reset (async assert, sync release) sets CURSOR_X/Y=0, SCROLL_ROW=0, FB_WE=0, FB_ADDR=0, FB_DATA=FILL_CHAR, state=CLEAR.
  - DIN_READY=0 and BUSY=1 until the post-reset sweep finishes.
- The physical row of a logical row y is (y+SCROLL_ROW) mod ROWS. Mod is done by compare-and-subtract; ROWS need not be a power of two.
- Handshake: a transfer occurs when DIN_VALID&&DIN_READY. DIN_READY=1 only in IDLE. The code is latched on transfer.
- States:
  - IDLE: on transfer, go to EXEC.
  - EXEC: one cycle; decode the latched code, then return to IDLE unless a sweep starts.
    - Maximum throughput is one code per 2 cycles.
  - CLEAR: sweep addresses 0..COLS*ROWS-1, one per cycle, FB_WE=1, FB_DATA=FILL_CHAR. Then set cursor=(0,0), SCROLL_ROW=0, and go to IDLE.
  - CLRLINE: sweep the COLS cells of one physical row with FILL_CHAR, then go to IDLE.
- Decode in EXEC:
  - 0x0A (LF): if CURSOR_Y<ROWS-1, CURSOR_Y+1. Otherwise SCROLL_ROW+1 (wraps ROWS-1 -> 0), CURSOR_Y stays, enter CLRLINE on the new bottom physical row.
  - 0x0D (CR): CURSOR_X=0.
  - 0x08 (BS): if CURSOR_X>0, CURSOR_X-1 and write FILL_CHAR at the new position. At column 0, no effect; no reverse line wrap.
  - 0x7F: enter CLEAR.
  - Other codes <0x20: ignored; no write.
  - Printable (>=0x20, !=0x7F): FB_WE=1 one cycle after transfer at the current physical cell, then CURSOR_X+1.
    - If CURSOR_X was COLS-1: CURSOR_X=0 and perform the LF action, including scroll at the bottom row.
- The FB write from EXEC coincides with the cycle after acceptance. Write latency from transfer = 1 cycle.
- Sweeps: FB_WE stays high continuously. A CLEAR takes COLS*ROWS cycles; a CLRLINE takes COLS cycles.
- DIN held valid during a sweep is not lost; it is accepted on the first IDLE cycle.
- Reset asserted mid-sweep or mid-EXEC aborts immediately and restarts the full CLEAR.
- CURSOR_X never exceeds COLS-1; CURSOR_Y never exceeds ROWS-1; SCROLL_ROW never exceeds ROWS-1.

Optional Feature:
- Macro: TEXT_CONSOLE_TAB_EN.
- Defined: 0x09 (HT) sets CURSOR_X to the next multiple of 8, without writing the skipped cells.
  - If the result is >=COLS, CURSOR_X=0 and perform the LF action, including scroll.
  - Done in EXEC; no extra cycles.
- Undefined: 0x09 falls under "other control codes" and is ignored; no cursor change, no write.

Test Plan:
- Release reset -> BUSY=1 for exactly 2400 cycles (80x30); FB_WE high on addresses 0..2399 with data 0; then DIN_READY=1, cursor (0,0), SCROLL_ROW=0.
- Send 0x41 then 0x42 -> writes at addr 0=0x41, addr 1=0x42; each FB_WE one cycle after its transfer; CURSOR_X=2.
- Send 80 printable codes at row 0 -> last write at addr 79; cursor becomes (0,1), no scroll.
- Move cursor to row 29, send 0x0A -> SCROLL_ROW=1, CURSOR_Y=29, 80-cycle CLRLINE on addrs 0..79 (physical row 0); then 0x43 writes to addr 0+CURSOR_X.
- Scroll 30 times from the bottom row -> SCROLL_ROW wraps 29->0; then send 0x7F -> full 2400-cycle clear, cursor (0,0), SCROLL_ROW=0.
- 0x08 at column 0 -> no write, no change. With TEXT_CONSOLE_TAB_EN at X=75, send 0x09 -> cursor (0,Y+1); at X=3 -> X=8.
